// File: rtl/spi_reg_bank.sv
// spi_reg_bank: write-oriented SPI (mode 0) peripheral feeding a small control
// register file that drives the output enables, PWM enables and PWM duty cycle.
//
// Frames are 16 bits, MSB first: {R/W (1 = write), address[6:0], data[7:0]}.
// A write commits on the clk edge at which the synchronized ncs rising edge is
// detected, and only when exactly 16 bits were shifted in and the address is
// below NUM_REGS. Every other frame is dropped without side effects.
//
// Optional build macro: SPI_READBACK_EN
//   Defined   : R/W = 0 frames are reads; after the 8th sclk rising edge cipo_oe
//               goes high and cipo presents the addressed register MSB first
//               (0x00 for an out-of-range address).
//   Undefined : cipo and cipo_oe are tied low and read frames are discarded.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, ncs, copi     SPI inputs, asynchronous to clk
//   cipo, cipo_oe       SPI read data and its output enable
//   en_reg_out_7_0      register 0x00
//   en_reg_out_15_8     register 0x01
//   en_reg_pwm_7_0      register 0x02
//   en_reg_pwm_15_8     register 0x03
//   pwm_duty_cycle      register 0x04
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  // Input synchronizers
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  // Fills with ones after reset; its last bit marks the point where the
  // synchronizer outputs reflect the pins rather than their reset values.
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_sclk_d;
  logic                   r_ncs_d;

  logic w_sclk_s;
  logic w_ncs_s;
  logic w_copi_s;
  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_warm      <= '0;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_ncs_d     <= w_ncs_s;
    end
  end

  // Frame capture and commit
  logic        r_armed;   // ncs has been seen idle (high) since reset
  logic        r_active;  // inside a frame that began with a genuine ncs fall
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic [7:0]  r_regs [NUM_REGS];

  logic [6:0] w_addr;
  logic       w_addr_valid;
  logic       w_commit_ok;
  logic       w_shift_en;

  assign w_addr       = r_shift[14:8];
  assign w_addr_valid = (32'(w_addr) < 32'(NUM_REGS));
  assign w_commit_ok  = r_active && (r_bit_cnt == 5'd16) && r_shift[15] && w_addr_valid;
  assign w_shift_en   = r_active && !w_ncs_s && w_sclk_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed   <= 1'b0;
      r_active  <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      // If ncs is still low when reset is released, the synchronizer falls
      // from its idle reset value; that is not a real frame start, so frames
      // are only accepted once ncs has genuinely been high.
      if (r_warm[SYNC_STAGES-1] && w_ncs_s) r_armed <= 1'b1;

      if (w_ncs_fall && r_armed) begin
        r_active  <= 1'b1;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[14:0], w_copi_s};
        // Saturate at 17 so arbitrarily long frames never wrap back to 16.
        if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
      end

      if (w_ncs_rise) begin
        r_active <= 1'b0;
        if (w_commit_ok) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (w_addr == 7'(i)) r_regs[i] <= r_shift[7:0];
        end
      end
    end
  end

  // Map the register file onto the fixed output ports; addresses beyond
  // NUM_REGS read as zero.
  logic [7:0] w_reg_out [5];

  for (genvar gi = 0; gi < 5; gi++) begin : g_out
    if (gi < NUM_REGS) begin : g_impl
      assign w_reg_out[gi] = r_regs[gi];
    end else begin : g_zero
      assign w_reg_out[gi] = 8'h00;
    end
  end

  assign en_reg_out_7_0  = w_reg_out[0];
  assign en_reg_out_15_8 = w_reg_out[1];
  assign en_reg_pwm_7_0  = w_reg_out[2];
  assign en_reg_pwm_15_8 = w_reg_out[3];
  assign pwm_duty_cycle  = w_reg_out[4];

`ifdef SPI_READBACK_EN
  logic       r_cipo;
  logic       r_cipo_oe;
  logic [7:0] r_tx;

  logic       w_sclk_fall;
  logic [7:0] w_rx_next;
  logic [7:0] w_rd_data;

  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  // Header byte as it will look once the current sclk rise has shifted in.
  assign w_rx_next   = {r_shift[6:0], w_copi_s};

  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_rx_next[6:0] == 7'(i)) w_rd_data = r_regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cipo    <= 1'b0;
      r_cipo_oe <= 1'b0;
      r_tx      <= 8'h00;
    end else if (w_ncs_rise) begin
      r_cipo    <= 1'b0;
      r_cipo_oe <= 1'b0;
    end else if (w_shift_en && (r_bit_cnt == 5'd7) && !w_rx_next[7]) begin
      // 8th rising edge of a read: present bit 7 immediately.
      r_cipo_oe <= 1'b1;
      r_cipo    <= w_rd_data[7];
      r_tx      <= {w_rd_data[6:0], 1'b0};
    end else if (r_cipo_oe && w_sclk_fall && (r_bit_cnt >= 5'd9)) begin
      // Advance only after the controller has sampled the current bit, so
      // bit 7 is held through the 9th rising edge.
      r_cipo <= r_tx[7];
      r_tx   <= {r_tx[6:0], 1'b0};
    end
  end

  assign cipo    = r_cipo;
  assign cipo_oe = r_cipo_oe;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ncs = 1'b1;
  logic       copi = 1'b0;
  logic       cipo;
  logic       cipo_oe;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_reg_bank #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .ncs             (ncs),
    .copi            (copi),
    .cipo            (cipo),
    .cipo_oe         (cipo_oe),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  logic [7:0] dut_regs [5];
  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  // Reference model: the register file as the controller believes it to be.
  logic [7:0] mdl [5];

  task automatic model_reset();
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
  endtask

  // Only an exact 16-bit write to an existing address lands.
  task automatic model_frame(input logic [31:0] bits, input int nbits);
    int a;
    a = int'(bits[14:8]);
    if (nbits == 16 && bits[15] && a < 5) mdl[a] = bits[7:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s reg%0d", tag, i), 32'(dut_regs[i]), 32'(mdl[i]));
    chk($sformatf("%s cipo_oe", tag), 32'(cipo_oe), 32'd0);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts nbits (bits[nbits-1] first) with 6-clk sclk phases. When chk_rd is
  // set, cipo/cipo_oe are checked just before each rising edge.
  task automatic send_bits(input logic [31:0] bits, input int nbits,
                           input bit chk_rd, input logic [7:0] rd_byte);
    int j;
    for (int k = nbits - 1; k >= 0; k--) begin
      j = nbits - 1 - k;
      copi = bits[k];
      clks(6);
      if (chk_rd) begin
`ifdef SPI_READBACK_EN
        if (j >= 8) begin
          chk($sformatf("rd oe bit%0d", j), 32'(cipo_oe), 32'd1);
          chk($sformatf("rd cipo bit%0d", j), 32'(cipo), 32'(rd_byte[15 - j]));
        end else begin
          chk($sformatf("rd oe hdr%0d", j), 32'(cipo_oe), 32'd0);
        end
`else
        chk($sformatf("rd oe bit%0d", j), 32'(cipo_oe), 32'd0);
        chk($sformatf("rd cipo bit%0d", j), 32'(cipo), 32'd0);
        if (j == 0) chk("rd byte unused", 32'(rd_byte & 8'h00), 32'd0);
`endif
      end
      sclk = 1'b1;
      clks(6);
      sclk = 1'b0;
    end
    clks(6);
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int nbits,
                           input bit chk_rd, input logic [7:0] rd_byte);
    ncs = 1'b0;
    clks(6);
    send_bits(bits, nbits, chk_rd, rd_byte);
  endtask

  task automatic end_frame();
    ncs = 1'b1;
    copi = 1'b0;
    clks(8);
  endtask

  typedef struct {
    logic [31:0]     bits;
    int              nbits;
    logic [4:0][7:0] exp;   // {reg4, reg3, reg2, reg1, reg0} after the frame
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [15:0] f;
    int          nb;
    logic [31:0] b;

    vecs[0]  = '{32'h80FF,  16, 40'h00_00_00_00_FF};
    vecs[1]  = '{32'h8480,  16, 40'h80_00_00_00_FF};
    vecs[2]  = '{32'h85AA,  16, 40'h80_00_00_00_FF};  // address 5: out of range
    vecs[3]  = '{32'h40D5,  15, 40'h80_00_00_00_FF};  // first 15 bits of 0x81AA
    vecs[4]  = '{32'h10355, 17, 40'h80_00_00_00_FF};  // 0x81AA plus one extra bit
    vecs[5]  = '{32'h0311,  16, 40'h80_00_00_00_FF};  // R/W = 0
    vecs[6]  = '{32'h8311,  16, 40'h80_11_00_00_FF};
    vecs[7]  = '{32'h8222,  16, 40'h80_11_22_00_FF};
    vecs[8]  = '{32'h8133,  16, 40'h80_11_22_33_FF};
    vecs[9]  = '{32'hFF44,  16, 40'h80_11_22_33_FF};  // address 0x7F
    vecs[10] = '{32'h8437,  16, 40'h37_11_22_33_FF};

    model_reset();
    clks(5);
    rst = 1'b0;
    clks(1);
    check_all("reset");
    chk("reset cipo", 32'(cipo), 32'd0);
    clks(4);

    // Table-driven frames
    for (int v = 0; v < 11; v++) begin
      spi_frame(vecs[v].bits, vecs[v].nbits, 1'b0, 8'h00);
      end_frame();
      model_frame(vecs[v].bits, vecs[v].nbits);
      for (int i = 0; i < 5; i++)
        chk($sformatf("vec%0d reg%0d", v, i), 32'(dut_regs[i]), 32'(vecs[v].exp[i]));
      chk($sformatf("vec%0d cipo_oe", v), 32'(cipo_oe), 32'd0);
      $display("vec %0d: frame 0x%0h (%0d bits) applied", v, vecs[v].bits, vecs[v].nbits);
    end

    // Commit latency: output changes on the 3rd clk edge after ncs rises.
    spi_frame(32'h8455, 16, 1'b0, 8'h00);
    ncs = 1'b1;
    copi = 1'b0;
    clks(2);
    chk("latency edge2", 32'(pwm_duty_cycle), 32'h37);
    clks(1);
    chk("latency edge3", 32'(pwm_duty_cycle), 32'h55);
    clks(6);
    model_frame(32'h8455, 16);
    check_all("latency");
    $display("latency sequence: frame 0x8455");

    // Reset mid-frame, remaining 8 bits clocked with ncs still low.
    spi_frame(32'h82, 8, 1'b0, 8'h00);
    rst = 1'b1;
    clks(5);
    rst = 1'b0;
    model_reset();
    clks(4);
    send_bits(32'hF0, 8, 1'b0, 8'h00);
    end_frame();
    check_all("rst midframe");
    spi_frame(32'h82F0, 16, 1'b0, 8'h00);
    end_frame();
    model_frame(32'h82F0, 16);
    check_all("after rst frame");
    $display("reset mid-frame sequence done");

    // Reset mid-frame, then a complete 16-bit frame without a fresh ncs fall.
    spi_frame(32'h83, 8, 1'b0, 8'h00);
    rst = 1'b1;
    clks(5);
    rst = 1'b0;
    model_reset();
    clks(4);
    send_bits(32'h83A5, 16, 1'b0, 8'h00);
    end_frame();
    check_all("rst no fall");
    $display("reset with ncs low sequence done");

    // Randomized frames against the model
    for (int t = 0; t < 40; t++) begin
      f = 16'($urandom);
      f[14:8] = 7'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) f[15] = 1'b1;
      case ($urandom_range(0, 5))
        0:       begin nb = 15; b = 32'(f >> 1); end
        1:       begin nb = 17; b = {15'd0, f, 1'($urandom)}; end
        default: begin nb = 16; b = 32'(f); end
      endcase
      spi_frame(b, nb, 1'b0, 8'h00);
      end_frame();
      model_frame(b, nb);
      check_all($sformatf("rand%0d", t));
      $display("rand %0d: frame 0x%0h (%0d bits)", t, b, nb);
    end

    // Read of register 4 after writing 0x37
    spi_frame(32'h8437, 16, 1'b0, 8'h00);
    end_frame();
    model_frame(32'h8437, 16);
    spi_frame(32'h0400, 16, 1'b1, 8'h37);
    end_frame();
    check_all("read 0x0400");
    $display("read sequence: frame 0x0400");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
